bargraph_meter: RTL and testbench

Parametrised successor to the pushbutton bar-graph and 3-to-8 decode logic: a registered N-segment level meter with peak-hold and timed peak decay. Each cycle it converts N raw active-high input lines to a level, the 1-based index of the highest set line. It drives a bar or single-dot display with a peak marker overlaid. It sits between the input bank (pb or equivalent) and the LED/segment outputs.

---
 rtl/meter_pkg.sv | 11 +
 rtl/level_encode.sv | 20 ++
 rtl/bargraph_meter.sv | 76 +++++++
 tb/tb_bargraph_meter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/meter_pkg.sv
// Shared types and width helpers for the bar-graph level meter.
package meter_pkg;

    typedef enum logic {MODE_BAR, MODE_DOT} meter_mode_t;

    // Bits needed to hold every value 0..n inclusive; never narrower than 1.
    function automatic int level_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/level_encode.sv
// Combinational priority encoder: 1-based index of the highest set line, 0 when idle.
module level_encode
    import meter_pkg::*;
#(
    parameter int N = 16,
    localparam int LW = level_width(N)
) (
    input  logic [N-1:0]  in,
    output logic [LW-1:0] level
);

    always_comb begin
        level = '0;
        // Ascending scan, so the highest set line is the last one written.
        for (int i = 0; i < N; i++) begin
            if (in[i]) level = LW'(i + 1);
        end
    end

endmodule

// File: rtl/bargraph_meter.sv
// Registered N-segment level meter with peak-hold, timed peak decay and bar/dot display.
module bargraph_meter
    import meter_pkg::*;
#(
    parameter int N           = 16,
    parameter int HOLD_TICKS  = 50,
    parameter int DECAY_TICKS = 10,
    localparam int LW = level_width(N)
) (
    input  logic          hz100,
    input  logic          reset,
    input  logic [N-1:0]  in,
    input  logic          mode,
    input  logic          freeze,
    input  logic          clear,
    output logic [N-1:0]  out,
    output logic [LW-1:0] level,
    output logic [LW-1:0] peak
);

    localparam int HW = level_width(HOLD_TICKS);
    localparam int DW = level_width(DECAY_TICKS);

    logic [LW-1:0] level_d;
    logic [LW-1:0] level_q;
    logic [LW-1:0] peak_q;
    logic [HW-1:0] hold_cnt;
    logic [DW-1:0] decay_cnt;

    level_encode #(.N(N)) u_encode (
        .in    (in),
        .level (level_d)
    );

    always_ff @(posedge hz100) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset || clear) begin
            level_q   <= '0;
            peak_q    <= '0;
            hold_cnt  <= '0;
            decay_cnt <= '0;
        end else if (!freeze) begin
            level_q <= level_d;
            if (level_d >= peak_q) begin
                peak_q    <= level_d;
                hold_cnt  <= HW'(HOLD_TICKS);
                decay_cnt <= '0;
            end else if (hold_cnt != '0) begin
                hold_cnt  <= hold_cnt - 1'b1;
                decay_cnt <= '0;
            end else if (decay_cnt == DW'(DECAY_TICKS - 1)) begin
                // level_d < peak_q here, so the decremented peak never undercuts the level.
                peak_q    <= peak_q - 1'b1;
                decay_cnt <= '0;
            end else begin
                decay_cnt <= decay_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        out = '0;
        for (int i = 0; i < N; i++) begin
            if (meter_mode_t'(mode) == MODE_DOT)
                out[i] = (level_q != '0) && (LW'(i) == level_q - 1'b1);
            else
                out[i] = (LW'(i) < level_q);
            if (peak_q != '0 && LW'(i) == peak_q - 1'b1)
                out[i] = 1'b1;
        end
    end

    assign level = level_q;
    assign peak  = peak_q;

endmodule

// File: tb/tb_bargraph_meter.sv
// Directed self-checking bench for bargraph_meter with N=16, HOLD_TICKS=4, DECAY_TICKS=2.
module tb_bargraph_meter;

    localparam int N  = 16;
    localparam int LW = 5;

    logic          hz100 = 1'b0;
    logic          reset;
    logic [N-1:0]  in;
    logic          mode;
    logic          freeze;
    logic          clear;
    logic [N-1:0]  out;
    logic [LW-1:0] level;
    logic [LW-1:0] peak;

    int checks   = 0;
    int failures = 0;

    bargraph_meter #(.N(N), .HOLD_TICKS(4), .DECAY_TICKS(2)) dut (
        .hz100  (hz100),
        .reset  (reset),
        .in     (in),
        .mode   (mode),
        .freeze (freeze),
        .clear  (clear),
        .out    (out),
        .level  (level),
        .peak   (peak)
    );

    always #5 hz100 = ~hz100;

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge hz100);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [LW-1:0] exp_level,
                             input logic [LW-1:0] exp_peak, input logic [N-1:0] exp_out);
        check({tag, "_level"}, 32'(level), 32'(exp_level));
        check({tag, "_peak"},  32'(peak),  32'(exp_peak));
        check({tag, "_out"},   32'(out),   32'(exp_out));
    endtask

    initial begin
        reset = 1'b0; in = 16'hFFFF; mode = 1'b0; freeze = 1'b0; clear = 1'b0;
        step(3);
        check_all("reset_hold", 0, 0, 16'h0000);

        reset = 1'b1; in = 16'h0080;
        step(1);
        check_all("bar_marker", 8, 8, 16'h00FF);

        // Drop to zero: hold 4 edges, then one step down every 2 edges.
        in = 16'h0000;
        step(1);  check_all("hold_e1", 0, 8, 16'h0080);
        step(3);  check_all("hold_e4", 0, 8, 16'h0080);
        step(1);  check("hold_e5_peak", 32'(peak), 8);
        step(1);  check("decay_e6_peak", 32'(peak), 7);
        step(4);  check("decay_e10_peak", 32'(peak), 5);
        step(9);  check_all("decay_e19", 0, 1, 16'h0001);
        step(1);  check_all("decay_e20", 0, 0, 16'h0000);

        // Rise during decay restarts the full hold.
        in = 16'h0080; step(1);
        in = 16'h0000; step(10);
        check("restart_pre_peak", 32'(peak), 5);
        in = 16'h0020; step(1);
        check_all("restart_rise", 6, 6, 16'h003F);
        in = 16'h0000; step(4);
        check("restart_hold4_peak", 32'(peak), 6);
        step(2);
        check("restart_decay_peak", 32'(peak), 5);

        // Dot mode with held peak; mode is combinational.
        in = 16'h0080; step(1);
        in = 16'h0004; mode = 1'b1; step(1);
        check_all("dot_mode", 3, 8, 16'h0084);
        mode = 1'b0; #1;
        check("bar_same_cycle_out", 32'(out), 32'h0087);

        // Freeze mid-hold resumes with exact counter values.
        in = 16'h0080; step(1);
        in = 16'h0000; step(2);
        freeze = 1'b1; in = 16'hFFFF; step(5);
        check_all("freeze_hold", 0, 8, 16'h0080);
        freeze = 1'b0; in = 16'h0000; step(2);
        check("resume_hold_end_peak", 32'(peak), 8);
        step(1);
        check("resume_decay_cnt_peak", 32'(peak), 8);
        step(1);
        check("resume_decay_step_peak", 32'(peak), 7);

        // Clear beats freeze.
        freeze = 1'b1; clear = 1'b1; in = 16'h0100; step(1);
        check_all("clear_over_freeze", 0, 0, 16'h0000);
        freeze = 1'b0; clear = 1'b0; step(1);
        check_all("after_clear", 9, 9, 16'h01FF);

        // Reset with clear low.
        reset = 1'b0; step(1);
        check_all("reset_mid_run", 0, 0, 16'h0000);

        // Top segment boundary: highest line wins over lowest.
        reset = 1'b1; in = 16'h8001; step(1);
        check_all("top_segment", 16, 16, 16'hFFFF);
        mode = 1'b1; #1;
        check("top_dot_out", 32'(out), 32'h8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
